// File: rtl/pic10_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pic10_sequencer: Q1-Q4 instruction-cycle controller for the PIC10 core.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pic10_sequencer #(
  parameter logic [11:0] NOP_WORD = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] prog_data,
  input  logic [7:0]  alu_bus,
  input  logic [7:0]  ram_data_bus,
  input  logic        wake,
  output logic [11:0] ir_reg_bus,
  output logic [1:0]  phase,
  output logic        w_we,
  output logic        ram_we,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        stack_push,
  output logic        stack_pop,
  output logic        z_flag,
  output logic        halted
);

  // The low two state bits are the phase and bit 2 is the halt flag.
  localparam logic [2:0] S_Q1   = 3'b000;
  localparam logic [2:0] S_Q2   = 3'b001;
  localparam logic [2:0] S_Q3   = 3'b010;
  localparam logic [2:0] S_Q4   = 3'b011;
  localparam logic [2:0] S_HALT = 3'b100;

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [11:0] r_ir;
  logic        r_z;
  logic        r_flush;
  logic        r_flush_inc;

  logic w_q4, w_exec;
  logic w_byte, w_bit_wr, w_btfsc, w_btfss, w_lit;
  logic w_retlw, w_call, w_goto, w_branch, w_sleep;
  logic w_zop, w_fsz, w_bit_val, w_alu_zero, w_skip;

  assign w_q4   = (r_state == S_Q4);
  assign w_exec = w_q4 & ~r_flush;

  // 0000_000x_xxxx is the miscellaneous group, not a byte op.
  assign w_byte    = (r_ir[11:10] == 2'b00) && (r_ir[9:5] != 5'd0);
  assign w_bit_wr  = (r_ir[11:9] == 3'b010);
  assign w_btfsc   = (r_ir[11:8] == 4'b0110);
  assign w_btfss   = (r_ir[11:8] == 4'b0111);
  assign w_lit     = (r_ir[11:10] == 2'b11);
  assign w_retlw   = (r_ir[11:8] == 4'b1000);
  assign w_call    = (r_ir[11:8] == 4'b1001);
  assign w_goto    = (r_ir[11:9] == 3'b101);
  assign w_branch  = w_retlw | w_call | w_goto;
  assign w_sleep   = (r_ir == 12'h003);

  // CLRF/CLRW (0001) through INCF (1010), plus IORLW/ANDLW/XORLW.
  assign w_zop = (w_byte && (r_ir[9:6] >= 4'd1) && (r_ir[9:6] <= 4'd10)) ||
                 (r_ir[11:8] == 4'b1101) || (r_ir[11:8] == 4'b1110) ||
                 (r_ir[11:8] == 4'b1111);
  assign w_fsz = w_byte && ((r_ir[9:6] == 4'b1011) || (r_ir[9:6] == 4'b1111));

  assign w_bit_val  = ram_data_bus[r_ir[7:5]];
  assign w_alu_zero = (alu_bus == 8'h00);
  assign w_skip     = (w_btfsc & ~w_bit_val) | (w_btfss & w_bit_val) |
                      (w_fsz & w_alu_zero);

  assign w_we       = w_exec & ((w_byte & ~r_ir[5]) | w_lit | w_retlw);
  assign ram_we     = w_exec & ((w_byte & r_ir[5]) | w_bit_wr);
  assign pc_load    = w_exec & w_branch;
  assign stack_push = w_exec & w_call;
  assign stack_pop  = w_exec & w_retlw;
  assign pc_inc     = w_q4 & (r_flush ? r_flush_inc : ~w_branch);

  assign ir_reg_bus = r_ir;
  assign phase      = r_state[1:0];
  assign halted     = r_state[2];
  assign z_flag     = r_z;

  always_comb begin
    w_state_nxt = S_Q1;
    case (r_state)
      S_Q1:    w_state_nxt = S_Q2;
      S_Q2:    w_state_nxt = S_Q3;
      S_Q3:    w_state_nxt = S_Q4;
      S_Q4:    w_state_nxt = (w_exec & w_sleep) ? S_HALT : S_Q1;
      S_HALT:  w_state_nxt = wake ? S_Q1 : S_HALT;
      default: w_state_nxt = S_Q1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_Q1;
      r_ir        <= NOP_WORD;
      r_z         <= 1'b0;
      r_flush     <= 1'b0;
      r_flush_inc <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_Q1) begin
        r_ir <= r_flush ? NOP_WORD : prog_data;
      end
      if (w_q4) begin
        // A flush cycle only retires itself; it never chains another.
        if (r_flush) begin
          r_flush     <= 1'b0;
          r_flush_inc <= 1'b0;
        end else if (w_branch) begin
          r_flush     <= 1'b1;
          r_flush_inc <= 1'b0;
        end else if (w_skip) begin
          r_flush     <= 1'b1;
          r_flush_inc <= 1'b1;
        end
        if (w_exec && w_zop) begin
          r_z <= w_alu_zero;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pic10_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pic10_sequencer: directed self-checking bench for pic10_sequencer.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pic10_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] prog_data = 12'h000;
  logic [7:0]  alu_bus = 8'h00;
  logic [7:0]  ram_data_bus = 8'h00;
  logic        wake = 1'b0;
  logic [11:0] ir_reg_bus;
  logic [1:0]  phase;
  logic        w_we, ram_we, pc_inc, pc_load, stack_push, stack_pop;
  logic        z_flag, halted;
  logic [5:0]  stb;

  int n_checks = 0;
  int n_fail   = 0;

  // Strobe order: {w_we, ram_we, pc_inc, pc_load, stack_push, stack_pop}
  localparam logic [5:0] STB_NONE  = 6'b000000;
  localparam logic [5:0] STB_WINC  = 6'b101000;
  localparam logic [5:0] STB_RINC  = 6'b011000;
  localparam logic [5:0] STB_INC   = 6'b001000;
  localparam logic [5:0] STB_GOTO  = 6'b000100;
  localparam logic [5:0] STB_CALL  = 6'b000110;
  localparam logic [5:0] STB_RETLW = 6'b100101;

  assign stb = {w_we, ram_we, pc_inc, pc_load, stack_push, stack_pop};

  pic10_sequencer #(.NOP_WORD(12'h000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .prog_data    (prog_data),
    .alu_bus      (alu_bus),
    .ram_data_bus (ram_data_bus),
    .wake         (wake),
    .ir_reg_bus   (ir_reg_bus),
    .phase        (phase),
    .w_we         (w_we),
    .ram_we       (ram_we),
    .pc_inc       (pc_inc),
    .pc_load      (pc_load),
    .stack_push   (stack_push),
    .stack_pop    (stack_pop),
    .z_flag       (z_flag),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".phase"}, 32'(phase), 32'd0);
    check({tag, ".ir"}, 32'(ir_reg_bus), 32'h000);
    check({tag, ".stb"}, 32'(stb), 32'(STB_NONE));
    check({tag, ".z"}, 32'(z_flag), 32'd0);
    check({tag, ".halted"}, 32'(halted), 32'd0);
  endtask

  // Enter at a negedge in Q1; leave at the negedge after the Q4 edge.
  task automatic instr(input string tag, input logic [11:0] word, input logic [7:0] alu,
                       input logic [7:0] ram, input logic [11:0] exp_ir,
                       input logic [5:0] exp_stb, input logic exp_z);
    prog_data = word;
    alu_bus = alu;
    ram_data_bus = ram;
    @(negedge clk);
    check({tag, ".ir"}, 32'(ir_reg_bus), 32'(exp_ir));
    check({tag, ".q2"}, 32'({phase, stb}), 32'({2'd1, STB_NONE}));
    @(negedge clk);
    check({tag, ".q3"}, 32'({phase, stb}), 32'({2'd2, STB_NONE}));
    @(negedge clk);
    check({tag, ".q4"}, 32'({phase, stb}), 32'({2'd3, exp_stb}));
    @(negedge clk);
    check({tag, ".q1"}, 32'({halted, phase, stb}), 32'({1'b0, 2'd0, STB_NONE}));
    check({tag, ".z"}, 32'(z_flag), 32'(exp_z));
  endtask

  initial begin
    #2;
    check_reset_state("rst");
    @(negedge clk);
    @(negedge clk);
    check_reset_state("rst_hold");
    rst_n = 1'b1;

    instr("addwf_a", 12'h1C0, 8'h04, 8'h00, 12'h1C0, STB_WINC, 1'b0);
    instr("addwf_b", 12'h1C0, 8'h04, 8'h00, 12'h1C0, STB_WINC, 1'b0);
    instr("bcf",     12'h421, 8'h00, 8'h00, 12'h421, STB_RINC, 1'b0);
    instr("iorlw",   12'hD00, 8'h00, 8'h00, 12'hD00, STB_WINC, 1'b1);
    instr("movlw",   12'hCF2, 8'hF2, 8'h00, 12'hCF2, STB_WINC, 1'b1);
    instr("addwf_c", 12'h1C0, 8'h04, 8'h00, 12'h1C0, STB_WINC, 1'b0);

    instr("goto",    12'hA05, 8'h00, 8'h00, 12'hA05, STB_GOTO, 1'b0);
    instr("goto_fl", 12'hFFF, 8'h00, 8'h00, 12'h000, STB_NONE, 1'b0);
    instr("movwf",   12'h025, 8'h00, 8'h00, 12'h025, STB_RINC, 1'b0);
    instr("call",    12'h910, 8'h00, 8'h00, 12'h910, STB_CALL, 1'b0);
    instr("call_fl", 12'hA05, 8'h00, 8'h00, 12'h000, STB_NONE, 1'b0);
    instr("retlw",   12'h8AB, 8'h00, 8'h00, 12'h8AB, STB_RETLW, 1'b0);
    instr("ret_fl",  12'hFFF, 8'h00, 8'h00, 12'h000, STB_NONE, 1'b0);

    instr("decfsz0", 12'h2E0, 8'h00, 8'h00, 12'h2E0, STB_RINC, 1'b0);
    instr("dec_fl",  12'hFFF, 8'h00, 8'h00, 12'h000, STB_INC, 1'b0);
    instr("decfsz1", 12'h2E0, 8'h01, 8'h00, 12'h2E0, STB_RINC, 1'b0);
    instr("noskip",  12'h1C0, 8'h00, 8'h00, 12'h1C0, STB_WINC, 1'b1);

    instr("btfsc",   12'h6E0, 8'h05, 8'h7F, 12'h6E0, STB_INC, 1'b1);
    instr("btc_fl",  12'hFFF, 8'h05, 8'h7F, 12'h000, STB_INC, 1'b1);
    instr("btfss",   12'h7E0, 8'h05, 8'h7F, 12'h7E0, STB_INC, 1'b1);
    instr("bts_nx",  12'h1C0, 8'h04, 8'h7F, 12'h1C0, STB_WINC, 1'b0);

    // SLEEP, then 20 halted clocks, then wake.
    prog_data = 12'h003;
    alu_bus = 8'h00;
    @(negedge clk);
    check("sleep.ir", 32'(ir_reg_bus), 32'h003);
    @(negedge clk);
    @(negedge clk);
    check("sleep.q4", 32'({phase, stb}), 32'({2'd3, STB_INC}));
    prog_data = 12'h1C0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halt.state", 32'({halted, phase, stb}), 32'({1'b1, 2'd0, STB_NONE}));
      check("halt.ir", 32'(ir_reg_bus), 32'h003);
    end
    wake = 1'b1;
    @(negedge clk);
    wake = 1'b0;
    check("wake.state", 32'({halted, phase}), 32'({1'b0, 2'd0}));
    check("wake.ir", 32'(ir_reg_bus), 32'h003);
    wake = 1'b1;
    instr("wake_run", 12'h1C0, 8'h00, 8'h00, 12'h1C0, STB_WINC, 1'b1);
    wake = 1'b0;

    // Reset during Q3: no write may escape.
    prog_data = 12'h1C0;
    alu_bus = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst.phase", 32'(phase), 32'd2);
    rst_n = 1'b0;
    #1;
    check_reset_state("rst_q3");
    @(negedge clk);
    check("rst_q3.hold_stb", 32'(stb), 32'(STB_NONE));
    rst_n = 1'b1;
    instr("post_rst", 12'h1C0, 8'h04, 8'h00, 12'h1C0, STB_WINC, 1'b0);

    // Reset during Q4 kills the live strobes at once.
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst4.q4", 32'({phase, stb}), 32'({2'd3, STB_WINC}));
    rst_n = 1'b0;
    #1;
    check_reset_state("rst_q4");
    @(negedge clk);
    rst_n = 1'b1;
    instr("post_rst4", 12'hD00, 8'h00, 8'h00, 12'hD00, STB_WINC, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
